// File: rtl/dmem_pkg.sv
// Shared definitions for the M-stage data memory responder: MMIO register
// offsets, STATUS bit layout, access-size decode and extra-class load codes.
package dmem_pkg;

  // MMIO register byte offsets within the 16-byte window
  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CYCLES = 4'h8;

  // STATUS register bit positions
  localparam int ST_CNT_LSB = 0;
  localparam int ST_EMPTY   = 2;
  localparam int ST_FULL    = 3;
  localparam int ST_OVF     = 4;
  localparam int ST_ERR     = 5;

  // Instruction class in Instr27_26M
  localparam logic [1:0] CLASS_EXTRA = 2'b00;
  localparam logic [1:0] CLASS_LDR   = 2'b01;

  // Extra-class load codes in Instr6_5M
  localparam logic [1:0] OP_LDRH  = 2'b01;
  localparam logic [1:0] OP_LDRSB = 2'b10;
  localparam logic [1:0] OP_LDRSH = 2'b11;

  typedef enum logic [1:0] {
    SZ_WORD,
    SZ_HALF,
    SZ_BYTE,
    SZ_NONE
  } access_size_e;

  // Lane-enable pattern to access size; anything irregular is SZ_NONE
  function automatic access_size_e decode_size(input logic [3:0] be);
    access_size_e sz;
    case (be)
      4'b1111:                            sz = SZ_WORD;
      4'b0011, 4'b1100:                   sz = SZ_HALF;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: sz = SZ_BYTE;
      default:                            sz = SZ_NONE;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/dbg_fifo.sv
// Circular-buffer FIFO for the debug TX stream. A push into a full FIFO is
// accepted only when a pop frees the head slot in the same cycle.
module dbg_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Occupancy flags and the qualified push/pop strobes
  always_comb begin
    empty   = (count == '0);
    full    = (count == FULL_COUNT);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  assign rdata = mem[rd_ptr];

  // Storage, pointers and occupancy count
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// M-stage data port responder: byte-enabled word RAM with load formatting,
// plus an MMIO window holding the debug TX FIFO, STATUS and a cycle counter.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [3:0]  byteEnable,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [1:0]  Instr27_26M,
  input  logic [1:0]  Instr6_5M,
  output logic [31:0] ReadDataM,
  output logic        dbg_valid,
  output logic [7:0]  dbg_data,
  input  logic        dbg_ready
);

  localparam int          RAM_AW    = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);
  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]       ram [DEPTH_WORDS];
  logic [RAM_AW-1:0] word_idx;
  logic [31:0]       raw_word;
  logic              is_ram;
  logic              is_mmio;
  logic              is_unmapped;
  logic [3:0]        mmio_off;

  logic              st_tx;
  logic              st_status;
  logic              st_cycles;
  logic              st_unmapped;

  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              fifo_pop;
  logic              ovf_set;
  logic              unused_count_msbs;

  logic              ovf;
  logic              err;
  logic [31:0]       cycles;
  logic [31:0]       status;

  // Byte/halfword lane pick and extension; irregular encodings pass raw
  function automatic logic [31:0] format_load(input logic [31:0] raw,
                                              input logic [3:0]  be,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  cls,
                                              input logic [1:0]  op);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lane)
      2'd0:    b = raw[7:0];
      2'd1:    b = raw[15:8];
      2'd2:    b = raw[23:16];
      default: b = raw[31:24];
    endcase
    h   = lane[1] ? raw[31:16] : raw[15:0];
    res = raw;
    case (decode_size(be))
      SZ_BYTE: begin
        if (cls == CLASS_LDR) begin
          res = {24'b0, b};
        end else if (cls == CLASS_EXTRA && op == OP_LDRSB) begin
          res = {{24{b[7]}}, b};
        end
      end
      SZ_HALF: begin
        if (cls == CLASS_EXTRA && op == OP_LDRH) begin
          res = {16'b0, h};
        end else if (cls == CLASS_EXTRA && op == OP_LDRSH) begin
          res = {{16{h[15]}}, h};
        end
      end
      default: res = raw;
    endcase
    return res;
  endfunction

  // Address decode and per-register store strobes
  always_comb begin
    is_ram      = (ALUResultM < RAM_BYTES);
    is_mmio     = !is_ram && (ALUResultM[31:4] == MMIO_BASE[31:4]);
    is_unmapped = !is_ram && !is_mmio;
    mmio_off    = {ALUResultM[3:2], 2'b00};
    word_idx    = ALUResultM[RAM_AW+1:2];
    st_tx       = MemWriteM && is_mmio && (mmio_off == OFF_TXDATA);
    st_status   = MemWriteM && is_mmio && (mmio_off == OFF_STATUS);
    st_cycles   = MemWriteM && is_mmio && (mmio_off == OFF_CYCLES);
    st_unmapped = MemWriteM && is_unmapped;
  end

  // Lane-masked RAM writes; contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (MemWriteM && is_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEnable[i]) begin
          ram[word_idx][8*i +: 8] <= WriteDataM[8*i +: 8];
        end
      end
    end
  end

  assign raw_word = ram[word_idx];

  assign dbg_valid = !fifo_empty;
  assign fifo_pop  = dbg_valid && dbg_ready;
  // A push only overflows when nothing leaves the full FIFO that cycle
  assign ovf_set   = st_tx && fifo_full && !fifo_pop;

  dbg_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_dbg_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (st_tx),
    .wdata (WriteDataM[7:0]),
    .pop   (fifo_pop),
    .rdata (dbg_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // STATUS only reports the low two count bits; a full FIFO reads as 0 there
  assign unused_count_msbs = ^fifo_count[CW-1:2];

  // Sticky flags: a STATUS store clears, a same-cycle set takes priority
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
      err <= 1'b0;
    end else begin
      if (st_status) begin
        ovf <= 1'b0;
        err <= 1'b0;
      end
      if (ovf_set) begin
        ovf <= 1'b1;
      end
      if (st_unmapped) begin
        err <= 1'b1;
      end
    end
  end

  // Free-running cycle counter, loadable by a CYCLES store
  always_ff @(posedge clk) begin
    if (reset) begin
      cycles <= '0;
    end else if (st_cycles) begin
      cycles <= WriteDataM;
    end else begin
      cycles <= cycles + 32'd1;
    end
  end

  // STATUS word assembly
  always_comb begin
    status                   = '0;
    status[ST_CNT_LSB +: 2]  = fifo_count[1:0];
    status[ST_EMPTY]         = fifo_empty;
    status[ST_FULL]          = fifo_full;
    status[ST_OVF]           = ovf;
    status[ST_ERR]           = err;
  end

  // Load data: formatted RAM word, MMIO register, or zero when unmapped
  always_comb begin
    ReadDataM = '0;
    if (is_ram) begin
      ReadDataM = format_load(raw_word, byteEnable, ALUResultM[1:0],
                              Instr27_26M, Instr6_5M);
    end else if (is_mmio) begin
      case (mmio_off)
        OFF_STATUS: ReadDataM = status;
        OFF_CYCLES: ReadDataM = cycles;
        default:    ReadDataM = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: per-feature tasks with inline
// checks, plus a queue scoreboard for bytes leaving the debug TX stream.
module tb_dmem_responder;

  localparam logic [31:0] A_TX = 32'hFFFF_0000;
  localparam logic [31:0] A_ST = 32'hFFFF_0004;
  localparam logic [31:0] A_CY = 32'hFFFF_0008;
  localparam logic [31:0] A_RS = 32'hFFFF_000C;
  localparam int          FDEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWriteM = 1'b0;
  logic [3:0]  byteEnable = 4'hF;
  logic [31:0] ALUResultM = '0;
  logic [31:0] WriteDataM = '0;
  logic [1:0]  Instr27_26M = 2'b01;
  logic [1:0]  Instr6_5M = 2'b00;
  logic [31:0] ReadDataM;
  logic        dbg_valid;
  logic [7:0]  dbg_data;
  logic        dbg_ready = 1'b0;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  logic        pop_m;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS (64),
    .FIFO_DEPTH  (FDEPTH),
    .MMIO_BASE   (32'hFFFF_0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .MemWriteM   (MemWriteM),
    .byteEnable  (byteEnable),
    .ALUResultM  (ALUResultM),
    .WriteDataM  (WriteDataM),
    .Instr27_26M (Instr27_26M),
    .Instr6_5M   (Instr6_5M),
    .ReadDataM   (ReadDataM),
    .dbg_valid   (dbg_valid),
    .dbg_data    (dbg_data),
    .dbg_ready   (dbg_ready)
  );

  // Scoreboard: model the FIFO from driven stimulus, compare each pop
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      checks++;
      if (dbg_valid !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL dbg_valid: got %b expected %b", dbg_valid, exp_q.size() != 0);
      end
      pop_m = dbg_ready && (exp_q.size() != 0);
      if (pop_m) begin
        checks++;
        if (dbg_data !== exp_q[0]) begin
          errors++;
          $display("FAIL dbg_data: got %h expected %h", dbg_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      if (MemWriteM && ALUResultM[31:4] == 28'hFFFF000 && ALUResultM[3:2] == 2'b00) begin
        if (exp_q.size() < FDEPTH) exp_q.push_back(WriteDataM[7:0]);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic [1:0] cls, input logic [1:0] op);
    MemWriteM   = we;
    ALUResultM  = a;
    WriteDataM  = d;
    byteEnable  = be;
    Instr27_26M = cls;
    Instr6_5M   = op;
  endtask

  task automatic store_word(input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, a, d, 4'hF, 2'b01, 2'b00);
    next_cycle();
    drive(1'b0, a, 32'h0, 4'hF, 2'b01, 2'b00);
  endtask

  task automatic test_reset();
    drive(1'b0, A_CY, 32'h0, 4'hF, 2'b01, 2'b00);
    @(negedge clk);
    checks += 3;
    if (ReadDataM !== 32'h0) begin errors++; $display("FAIL reset_cycles: got %h expected %h", ReadDataM, 32'h0); end
    if (dbg_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", dbg_valid); end
    if (dbg_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", dbg_data); end
    next_cycle();
    drive(1'b0, A_ST, 32'h0, 4'hF, 2'b01, 2'b00);
    @(negedge clk);
    checks++;
    if (ReadDataM !== 32'h4) begin errors++; $display("FAIL reset_status: got %h expected %h", ReadDataM, 32'h4); end
    next_cycle();
  endtask

  task automatic test_word_byte();
    store_word(32'h10, 32'hDEAD_BEEF);
    drive(1'b1, 32'h12, 32'h5555_5555, 4'b0100, 2'b01, 2'b00);
    next_cycle();
    drive(1'b0, 32'h10, 32'h0, 4'hF, 2'b01, 2'b00);
    @(negedge clk);
    checks++;
    if (ReadDataM !== 32'hDE55_BEEF) begin errors++; $display("FAIL word_byte: got %h expected %h", ReadDataM, 32'hDE55_BEEF); end
    next_cycle();
  endtask

  task automatic test_subword();
    logic [31:0] addr [5] = '{32'h23, 32'h23, 32'h22, 32'h20, 32'h23};
    logic [3:0]  be   [5] = '{4'b1000, 4'b1000, 4'b1100, 4'b0011, 4'b1111};
    logic [1:0]  cls  [5] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b01};
    logic [1:0]  op   [5] = '{2'b10, 2'b00, 2'b11, 2'b01, 2'b00};
    logic [31:0] exp  [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80F1, 32'h0000_7F01, 32'h80F1_7F01};
    store_word(32'h20, 32'h80F1_7F01);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, addr[i], 32'h0, be[i], cls[i], op[i]);
      @(negedge clk);
      checks++;
      if (ReadDataM !== exp[i]) begin
        errors++;
        $display("FAIL subword_%0d: got %h expected %h", i, ReadDataM, exp[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_fifo_overflow();
    dbg_ready = 1'b0;
    for (int i = 0; i < 5; i++) store_word(A_TX, 32'h41 + i);
    drive(1'b0, A_ST, 32'h0, 4'hF, 2'b01, 2'b00);
    @(negedge clk);
    checks++;
    if (ReadDataM !== 32'h18) begin errors++; $display("FAIL ovf_status: got %h expected %h", ReadDataM, 32'h18); end
    next_cycle();
    dbg_ready = 1'b1;
    repeat (6) next_cycle();
    @(negedge clk);
    checks += 2;
    if (ReadDataM !== 32'h14) begin errors++; $display("FAIL drained_status: got %h expected %h", ReadDataM, 32'h14); end
    if (dbg_valid !== 1'b0) begin errors++; $display("FAIL drained_valid: got %b expected 0", dbg_valid); end
    next_cycle();
    store_word(A_ST, 32'h0);
    @(negedge clk);
    checks++;
    if (ReadDataM !== 32'h4) begin errors++; $display("FAIL cleared_status: got %h expected %h", ReadDataM, 32'h4); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    dbg_ready = 1'b0;
    for (int i = 0; i < 4; i++) store_word(A_TX, 32'h91 + i);
    drive(1'b0, A_ST, 32'h0, 4'hF, 2'b01, 2'b00);
    @(negedge clk);
    checks++;
    if (ReadDataM !== 32'h08) begin errors++; $display("FAIL full_status: got %h expected %h", ReadDataM, 32'h08); end
    next_cycle();
    dbg_ready = 1'b1;
    drive(1'b1, A_TX, 32'h99, 4'hF, 2'b01, 2'b00);
    next_cycle();
    drive(1'b0, A_ST, 32'h0, 4'hF, 2'b01, 2'b00);
    @(negedge clk);
    checks++;
    if (ReadDataM !== 32'h08) begin errors++; $display("FAIL pushpop_status: got %h expected %h", ReadDataM, 32'h08); end
    next_cycle();
    repeat (5) next_cycle();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL pushpop_drain: got %0d left expected 0", exp_q.size()); end
    dbg_ready = 1'b0;
  endtask

  task automatic test_cycles();
    logic [31:0] exp [3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
    store_word(A_CY, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ReadDataM !== exp[i]) begin
        errors++;
        $display("FAIL cycles_%0d: got %h expected %h", i, ReadDataM, exp[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_unmapped_reset();
    logic [31:0] addr [4] = '{A_ST, 32'h0000_1000, A_RS, A_TX};
    logic [31:0] exp  [4] = '{32'h24, 32'h0, 32'h0, 32'h0};
    store_word(32'h0000_1000, 32'h1234_5678);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, addr[i], 32'h0, 4'hF, 2'b01, 2'b00);
      @(negedge clk);
      checks++;
      if (ReadDataM !== exp[i]) begin
        errors++;
        $display("FAIL unmapped_%0d: got %h expected %h", i, ReadDataM, exp[i]);
      end
      next_cycle();
    end
    dbg_ready = 1'b0;
    store_word(A_TX, 32'hA1);
    store_word(A_TX, 32'hA2);
    drive(1'b0, A_CY, 32'h0, 4'hF, 2'b01, 2'b00);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    checks += 2;
    if (dbg_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", dbg_valid); end
    if (ReadDataM !== 32'h0) begin errors++; $display("FAIL rst_cycles: got %h expected %h", ReadDataM, 32'h0); end
    next_cycle();
    drive(1'b0, A_ST, 32'h0, 4'hF, 2'b01, 2'b00);
    @(negedge clk);
    checks++;
    if (ReadDataM !== 32'h4) begin errors++; $display("FAIL rst_status: got %h expected %h", ReadDataM, 32'h4); end
    next_cycle();
    drive(1'b0, 32'h10, 32'h0, 4'hF, 2'b01, 2'b00);
    @(negedge clk);
    checks++;
    if (ReadDataM !== 32'hDE55_BEEF) begin errors++; $display("FAIL rst_ram_kept: got %h expected %h", ReadDataM, 32'hDE55_BEEF); end
    next_cycle();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_word_byte();
    test_subword();
    test_fifo_overflow();
    test_back_to_back();
    test_cycles();
    test_unmapped_reset();
    repeat (2) next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
